ex_div_seq: RTL and testbench
=============================

// Module: ex_div_seq
// PURPOSE
//   Multi-cycle restoring divider for the EX stage; executes DIV/DIVU, signed or unsigned.
//   EX drives operands and start_i, and holds the pipeline on stall_req_o until ready_o.
//   EX then writes the quotient and remainder to HI/LO.
//   Width is parametrised and one quotient bit is produced per clock.
// PARAMETERS
//   WIDTH  32  operand width; quotient and remainder are each WIDTH bits; must be >= 2
// PORTS
//   clk          in   1        rising-edge clock
//   rst          in   1        reset: synchronous, active-high
//   signed_div_i in   1        1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i in FREE
//   opdata1_i    in   WIDTH    dividend; sampled with start_i in FREE
//   opdata2_i    in   WIDTH    divisor; sampled with start_i in FREE
//   start_i      in   1        request; held high by EX until it consumes ready_o
//   annul_i      in   1        abort the current divide (branch delay flush / exception)
//   result_o     out  2*WIDTH  {remainder, quotient}; valid only while ready_o=1
//   ready_o      out  1        result valid (registered)
//   stall_req_o  out  1        combinational: start_i & ~ready_o & ~annul_i
// BEHAVIOUR
//   Reset: state=FREE, ready_o=0, result_o=0, internal counter=0, all datapath registers=0.
//   Reset mid-divide aborts the divide immediately, with no residual output.
//   States: FREE, BYZERO, ON, END (2-bit register).
//   FREE:
//     - start_i=1 and annul_i=0: opdata2_i==0 -> BYZERO; otherwise -> ON.
//     - On entry to ON: latch |opdata1_i| and |opdata2_i| (two's-complement negate when
//       signed_div_i=1 and MSB=1); latch the sign flags; clear the counter and remainder.
//     - annul_i=1 blocks the start; stay in FREE.
//   ON, one restoring step per clock:
//     - {rem,dvd} <<= 1; if rem >= dvs then rem -= dvs and shift in quotient bit 1, else 0.
//     - rem is WIDTH+1 bits wide to hold the compare.
//     - Counter runs 0..WIDTH-1; the step with counter==WIDTH-1 is the last one.
//     - After the last step -> END, registering the result:
//       quotient negated if signed and signs differ;
//       remainder negated if signed and dividend negative.
//       The remainder takes the sign of the dividend.
//   BYZERO: next clock -> END, result_o=0 (quotient=0, remainder=0).
//   END:
//     - ready_o=1 and result_o held.
//     - start_i=0 at the edge -> FREE, ready_o=0, result_o=0.
//     - start_i still 1 -> stay in END; no restart without first leaving END.
//   annul_i=1 in ON, BYZERO or END -> FREE at the next edge: ready_o=0, result_o=0, no result.
//   Latency: start_i first high in cycle 0 (state FREE), divisor != 0 -> ready_o=1 in
//   cycle WIDTH+1. Divisor == 0 -> ready_o=1 in cycle 2.
//   Overflow: signed MIN / -1 -> quotient=MIN (wraps), remainder=0; no trap raised.
//   Unsigned operand MSB=1 is full-range; no sign handling.
//   Operand changes after the start is accepted are ignored.
// TESTING
//   - WIDTH=32, DIVU 100/7, start_i held high:
//     quotient=14, remainder=2, ready_o=1 in cycle 33, stall_req_o=1 in cycles 0..32.
//   - DIV -7/2 (0xFFFFFFF9 / 0x2): quotient=0xFFFFFFFD, remainder=0xFFFFFFFF;
//     DIV 7/-2: quotient=0xFFFFFFFD, remainder=0x1.
//   - Divide by zero, DIVU 5/0:
//     ready_o=1 in cycle 2, result_o=0; drop start_i -> FREE, ready_o=0 the next cycle.
//   - annul_i=1 in cycle 10 of a divide:
//     FREE the next cycle, ready_o never set; then DIVU 9/3 -> quotient=3, remainder=0.
//   - DIV 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0;
//     DIVU same operands: quotient=0, remainder=0x80000000.
//   - WIDTH=8: DIVU 0xFF/0x01 -> quotient=0xFF, remainder=0 in cycle 9;
//     rst=1 in cycle 4 -> FREE, outputs 0 the next cycle.

Source files
------------

// File: rtl/ex_div_seq.sv
// Multi-cycle restoring divider for the EX stage (DIV/DIVU).
// It produces one quotient bit per clock and returns {remainder, quotient}.
module ex_div_seq #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_div_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 start_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o,
   output logic                 stall_req_o
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   localparam logic [1:0] S_FREE   = 2'd0;
   localparam logic [1:0] S_BYZERO = 2'd1;
   localparam logic [1:0] S_ON     = 2'd2;
   localparam logic [1:0] S_END    = 2'd3;

   logic [1:0]              state;
   logic [CNT_W-1:0]        cnt;
   logic [WIDTH-1:0]        dvd;
   logic [WIDTH-1:0]        dvs;
   logic [WIDTH:0]          rem;
   logic                    neg_q;
   logic                    neg_r;

   logic signed [WIDTH-1:0] op1_s;
   logic signed [WIDTH-1:0] op2_s;
   logic                    op1_neg;
   logic                    op2_neg;
   logic [WIDTH-1:0]        abs1;
   logic [WIDTH-1:0]        abs2;
   logic [WIDTH:0]          rem_sh;
   logic [WIDTH:0]          rem_diff;
   logic [WIDTH:0]          rem_nx;
   logic                    q_bit;
   logic [WIDTH-1:0]        dvd_nx;

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? (~v + WIDTH'(1)) : v;
   endfunction

   assign stall_req_o = start_i & ~ready_o & ~annul_i;

   // Operand conditioning: magnitudes and sign flags sampled at start
   always_comb begin
      op1_s   = opdata1_i;
      op2_s   = opdata2_i;
      op1_neg = signed_div_i & op1_s[WIDTH-1];
      op2_neg = signed_div_i & op2_s[WIDTH-1];
      abs1    = cond_neg(op1_s, op1_neg);
      abs2    = cond_neg(op2_s, op2_neg);
   end

   // Restoring step: the quotient bits shift into the low end of dvd as the dividend leaves
   always_comb begin
      rem_sh   = (rem << 1) | {{WIDTH{1'b0}}, dvd[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, dvs};
      q_bit    = (rem_sh >= {1'b0, dvs});
      rem_nx   = q_bit ? rem_diff : rem_sh;
      dvd_nx   = {dvd[WIDTH-2:0], q_bit};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_FREE;
         cnt      <= '0;
         dvd      <= '0;
         dvs      <= '0;
         rem      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         ready_o  <= 1'b0;
         result_o <= '0;
      end else begin
         case (state)
            S_FREE: begin
               if (start_i && !annul_i) begin
                  if (opdata2_i == '0) begin
                     state <= S_BYZERO;
                  end else begin
                     state <= S_ON;
                     dvd   <= abs1;
                     dvs   <= abs2;
                     neg_q <= op1_neg ^ op2_neg;
                     neg_r <= op1_neg;
                     cnt   <= '0;
                     rem   <= '0;
                  end
               end
            end
            S_BYZERO: begin
               if (annul_i) begin
                  state <= S_FREE;
               end else begin
                  state    <= S_END;
                  ready_o  <= 1'b1;
                  result_o <= '0;
               end
            end
            S_ON: begin
               if (annul_i) begin
                  state    <= S_FREE;
                  ready_o  <= 1'b0;
                  result_o <= '0;
               end else begin
                  dvd <= dvd_nx;
                  rem <= rem_nx;
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == LAST) begin
                     state    <= S_END;
                     ready_o  <= 1'b1;
                     // The remainder follows the dividend sign; MIN / -1 wraps back to MIN
                     result_o <= {cond_neg(rem_nx[WIDTH-1:0], neg_r), cond_neg(dvd_nx, neg_q)};
                  end
               end
            end
            S_END: begin
               if (annul_i || !start_i) begin
                  state    <= S_FREE;
                  ready_o  <= 1'b0;
                  result_o <= '0;
               end
            end
            default: state <= S_FREE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_div_seq.sv
// Self-checking bench for ex_div_seq: a 32-bit vector table with a result scoreboard,
// plus annul, reset and 8-bit corner sequences.
module tb_ex_div_seq;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, sd, start, annul;
   logic [31:0] op1, op2;
   logic [63:0] result;
   logic        ready, stall;

   logic        rst8, sd8, start8, annul8;
   logic [7:0]  op1_8, op2_8;
   logic [15:0] result8;
   logic        ready8, stall8;

   ex_div_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .signed_div_i(sd), .opdata1_i(op1), .opdata2_i(op2),
      .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready), .stall_req_o(stall)
   );

   ex_div_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst8), .signed_div_i(sd8), .opdata1_i(op1_8), .opdata2_i(op2_8),
      .start_i(start8), .annul_i(annul8), .result_o(result8), .ready_o(ready8), .stall_req_o(stall8)
   );

   typedef struct {
      logic        sd;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      int          lat;
   } vec_t;

   vec_t        vecs[11];
   logic [63:0] sb[$];
   int          checks   = 0;
   int          failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_div(input int id, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r, input int lat);
      int          cyc;
      int          stall_bad;
      logic [63:0] expv;
      sd = s; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
      #1;
      sb.push_back({r, q});
      cyc = 0;
      stall_bad = 0;
      while (!ready && cyc < 200) begin
         if (!stall) stall_bad++;
         tick();
         cyc++;
         op1 = $urandom;
         op2 = $urandom;
         sd  = 1'($urandom_range(0, 1));
      end
      chk($sformatf("v%0d_latency", id), cyc, lat);
      chk($sformatf("v%0d_stall_busy", id), stall_bad, 0);
      chk($sformatf("v%0d_stall_done", id), stall, 0);
      expv = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
      chk($sformatf("v%0d_result", id), result, expv);
      tick();
      chk($sformatf("v%0d_hold_ready", id), ready, 1);
      chk($sformatf("v%0d_hold_result", id), result, expv);
      start = 1'b0;
      tick();
      chk($sformatf("v%0d_drop_ready", id), ready, 0);
      chk($sformatf("v%0d_drop_result", id), result, 0);
   endtask

   initial begin
      int          cyc;
      int          seen;

      vecs[0]  = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        33};
      vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
      vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        33};
      vecs[3]  = '{1'b0, 32'd5,          32'd0,        32'd0,        32'd0,        2};
      vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       33};
      vecs[5]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 33};
      vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0,        33};
      vecs[7]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,       32'hFFFF_FFFE, 33};
      vecs[8]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,        32'd0,        33};
      vecs[9]  = '{1'b1, 32'd5,          32'd0,        32'd0,        32'd0,        2};
      vecs[10] = '{1'b0, 32'd3,          32'd10,       32'd0,        32'd3,        33};

      rst = 1'b1; sd = 1'b0; start = 1'b0; annul = 1'b0; op1 = '0; op2 = '0;
      rst8 = 1'b1; sd8 = 1'b0; start8 = 1'b0; annul8 = 1'b0; op1_8 = '0; op2_8 = '0;
      tick();
      tick();
      chk("rst_ready", ready, 0);
      chk("rst_result", result, 0);
      chk("rst8_ready", ready8, 0);
      chk("rst8_result", result8, 0);
      rst = 1'b0;
      rst8 = 1'b0;
      tick();
      chk("idle_stall", stall, 0);

      for (int i = 0; i < 11; i++)
         run_div(i, vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].lat);

      // Annul in cycle 10 of a divide; nothing may come out afterwards
      sd = 1'b0; op1 = 32'hFFFF_FFFF; op2 = 32'd3; start = 1'b1; annul = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      annul = 1'b1;
      #1;
      chk("annul_stall_gate", stall, 0);
      tick();
      chk("annul_ready", ready, 0);
      chk("annul_result", result, 0);
      start = 1'b0; annul = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (ready) seen++;
      end
      chk("annul_no_result", seen, 0);
      run_div(20, 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

      // Annul while holding a divide-by-zero result in END
      sd = 1'b0; op1 = 32'd5; op2 = 32'd0; start = 1'b1;
      tick();
      tick();
      chk("end_annul_pre_ready", ready, 1);
      annul = 1'b1;
      tick();
      chk("end_annul_ready", ready, 0);
      chk("end_annul_result", result, 0);
      start = 1'b0; annul = 1'b0;
      tick();

      // 8-bit instance: full-range unsigned divide
      sd8 = 1'b0; op1_8 = 8'hFF; op2_8 = 8'h01; start8 = 1'b1;
      cyc = 0;
      while (!ready8 && cyc < 50) begin
         tick();
         cyc++;
      end
      chk("w8_latency", cyc, 9);
      chk("w8_result", result8, 16'h00FF);
      start8 = 1'b0;
      tick();
      chk("w8_drop_ready", ready8, 0);

      // 8-bit instance: reset in cycle 4 aborts with no residual output
      start8 = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      rst8 = 1'b1;
      tick();
      chk("w8_rst_ready", ready8, 0);
      chk("w8_rst_result", result8, 0);
      rst8 = 1'b0;
      start8 = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ready8 || result8 != 16'h0) seen++;
      end
      chk("w8_rst_no_result", seen, 0);

      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
